// File: rtl/mem_rr_arbiter.sv
// Shares one non-pipelined 256x16 memory port among NREQ requesters, one transaction in flight.
// Define MEM_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module mem_rr_arbiter #(
  parameter int unsigned NREQ = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_val_i,
  input  logic [NREQ-1:0]       req_wen_i,
  input  logic [NREQ-1:0][7:0]  req_addr_i,
  input  logic [NREQ-1:0][15:0] req_wdata_i,
  output logic [NREQ-1:0]       req_rdy_o,
  output logic [15:0]           req_rdata_o,
  output logic                  mem_val_o,
  output logic                  mem_wen_o,
  output logic [7:0]            mem_addr_o,
  output logic [15:0]           mem_wdata_o,
  input  logic [15:0]           mem_rdata_i,
  input  logic                  mem_rdy_i,
  output logic [NREQ-1:0]       gnt_o,
  output logic                  busy_o
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t          state_q;
  logic            mem_val_q;
  logic            mem_wen_q;
  logic [7:0]      mem_addr_q;
  logic [15:0]     mem_wdata_q;
  logic [15:0]     rdata_q;
  logic [NREQ-1:0] rdy_q;
  logic [NREQ-1:0] gnt_q;
  logic            busy_q;

  logic            win_vld_d;
  logic [IW-1:0]   win_idx_d;

`ifdef MEM_ARB_FIXED_PRIO_EN
  always_comb begin
    win_vld_d = 1'b0;
    win_idx_d = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!win_vld_d && req_val_i[i]) begin
        win_vld_d = 1'b1;
        win_idx_d = IW'(i);
      end
    end
  end
`else
  logic [IW-1:0] ptr_q;
  logic [IW-1:0] w_q;
  logic [IW-1:0] cand_idx;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    win_vld_d = 1'b0;
    win_idx_d = '0;
    cand_idx  = '0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      cand_idx = IW'((32'(ptr_q) + off) % NREQ);
      if (!win_vld_d && req_val_i[cand_idx]) begin
        win_vld_d = 1'b1;
        win_idx_d = cand_idx;
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_val_q   <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      rdy_q       <= '0;
      gnt_q       <= '0;
      busy_q      <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      ptr_q       <= IW'(NREQ - 1);
      w_q         <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (win_vld_d) begin
            mem_val_q   <= 1'b1;
            mem_wen_q   <= req_wen_i[win_idx_d];
            mem_addr_q  <= req_addr_i[win_idx_d];
            mem_wdata_q <= req_wdata_i[win_idx_d];
            gnt_q       <= NREQ'(1) << win_idx_d;
            busy_q      <= 1'b1;
`ifndef MEM_ARB_FIXED_PRIO_EN
            w_q         <= win_idx_d;
`endif
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_rdy_i) begin
            rdata_q   <= mem_rdata_i;
            mem_val_q <= 1'b0;
            rdy_q     <= gnt_q;
            state_q   <= RESP;
          end
        end
        RESP: begin
          rdy_q   <= '0;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
          ptr_q   <= w_q;
`endif
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_val_o   = mem_val_q;
  assign mem_wen_o   = mem_wen_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign req_rdy_o   = rdy_q;
  assign req_rdata_o = rdata_q;
  assign gnt_o       = gnt_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Bench for mem_rr_arbiter: directed scenarios then random traffic against a reference model.
// Honors MEM_ARB_FIXED_PRIO_EN for the expected arbitration order.
module tb_mem_rr_arbiter;
  localparam int unsigned NREQ = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NREQ-1:0]       req_val, req_wen, req_rdy_o;
  logic [NREQ-1:0][7:0]  req_addr;
  logic [NREQ-1:0][15:0] req_wdata;
  logic [15:0]           req_rdata_o;
  logic                  mem_val_o, mem_wen_o, mem_rdy;
  logic [7:0]            mem_addr_o;
  logic [15:0]           mem_wdata_o, mem_rdata;
  logic [NREQ-1:0]       gnt_o;
  logic                  busy_o;

  mem_rr_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk), .rst(rst),
    .req_val_i(req_val), .req_wen_i(req_wen), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_rdy_o(req_rdy_o), .req_rdata_o(req_rdata_o),
    .mem_val_o(mem_val_o), .mem_wen_o(mem_wen_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata), .mem_rdy_i(mem_rdy),
    .gnt_o(gnt_o), .busy_o(busy_o)
  );

  function automatic logic [15:0] init_word(int unsigned a);
    return (a == 32'h42) ? 16'hBEEF : 16'((a * 257) ^ 32'h5A3C);
  endfunction

  // Memory model: answers after mem_lat wait cycles, rdy for one cycle, logs each access.
  logic [15:0]  mem [256];
  int unsigned  mem_lat = 0;
  int unsigned  wcnt;
  logic         log_wen;
  logic [7:0]   log_addr;
  logic [15:0]  log_wdata;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = init_word(i);
    mem_rdy = 1'b0; mem_rdata = '0; wcnt = 0;
    log_wen = 1'b0; log_addr = '0; log_wdata = '0;
    forever begin
      @(negedge clk);
      if (mem_rdy) mem_rdy = 1'b0;
      else if (mem_val_o) begin
        if (wcnt >= mem_lat) begin
          mem_rdy   = 1'b1;
          mem_rdata = mem[mem_addr_o];
          if (mem_wen_o) mem[mem_addr_o] = mem_wdata_o;
          log_wen = mem_wen_o; log_addr = mem_addr_o; log_wdata = mem_wdata_o;
          wcnt = 0;
        end else wcnt++;
      end else wcnt = 0;
    end
  end

  int          checks, failures;
  int          last;
  logic [15:0] ref_mem [256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    chk("gnt_onehot0", 32'($onehot0(gnt_o)), 32'd1);
    chk("rdy_onehot0", 32'($onehot0(req_rdy_o)), 32'd1);
  endtask

  function automatic int exp_winner(logic [NREQ-1:0] v, int lst);
`ifdef MEM_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
`else
    for (int k = 1; k <= NREQ; k++) if (v[(lst + k) % NREQ]) return (lst + k) % NREQ;
`endif
    return -1;
  endfunction

  task automatic serve(output int w, output logic [15:0] rd, output logic [NREQ-1:0] g, output int n);
    w = -1; rd = '0; g = '0; n = 0;
    for (int i = 0; i < 200; i++) begin
      step(); n++;
      if (req_rdy_o != '0) begin
        for (int j = 0; j < NREQ; j++) if (req_rdy_o[j]) w = j;
        rd = req_rdata_o; g = gnt_o;
        return;
      end
    end
    chk("serve_timeout", 32'(n), 32'd0);
  endtask

  task automatic txn(input string tag, input int exp_ticks, output int w, output logic [15:0] rd);
    logic [NREQ-1:0] snap, g, eg;
    int ew, n;
    snap = req_val;
    ew = exp_winner(snap, last);
    serve(w, rd, g, n);
    chk({tag, "_winner"}, 32'(w), 32'(ew));
    if (w >= 0) begin
      eg = '0; eg[w] = 1'b1;
      chk({tag, "_gnt"}, 32'(g), 32'(eg));
      chk({tag, "_mem_wen"}, 32'(log_wen), 32'(req_wen[w]));
      chk({tag, "_mem_addr"}, 32'(log_addr), 32'(req_addr[w]));
      if (req_wen[w]) begin
        chk({tag, "_mem_wdata"}, 32'(log_wdata), 32'(req_wdata[w]));
        ref_mem[req_addr[w]] = req_wdata[w];
      end else begin
        chk({tag, "_rdata"}, 32'(rd), 32'(ref_mem[req_addr[w]]));
      end
      last = w;
    end
    if (exp_ticks > 0) chk({tag, "_latency"}, 32'(n), 32'(exp_ticks));
  endtask

  task automatic idle();
    req_val = '0;
    step(); step();
  endtask

  task automatic new_op(input int j);
    req_val[j]   = 1'b1;
    req_wen[j]   = 1'($urandom_range(0, 1));
    req_addr[j]  = 8'($urandom_range(0, 31));
    req_wdata[j] = 16'($urandom);
  endtask

  int              w, n;
  logic [15:0]     rd;
  logic [NREQ-1:0] g;

  initial begin
    checks = 0; failures = 0; last = NREQ - 1;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    req_val = '0; req_wen = '0; req_addr = '0; req_wdata = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_val", 32'(mem_val_o), 32'd0);
    chk("rst_mem_wen", 32'(mem_wen_o), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr_o), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata_o), 32'd0);
    chk("rst_gnt", 32'(gnt_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_rdy", 32'(req_rdy_o), 32'd0);
    chk("rst_rdata", 32'(req_rdata_o), 32'd0);
    rst = 1'b0;

    // Reset during ISSUE abandons the transaction; req1 then reads 0x10 from a clean start.
    mem_lat = 5;
    req_val[1] = 1'b1; req_wen[1] = 1'b0; req_addr[1] = 8'h10;
    step(); step();
    chk("t1_busy_issue", 32'(busy_o), 32'd1);
    chk("t1_memval_issue", 32'(mem_val_o), 32'd1);
    rst = 1'b1; #1;
    chk("t1_async_memval", 32'(mem_val_o), 32'd0);
    chk("t1_async_gnt", 32'(gnt_o), 32'd0);
    chk("t1_async_busy", 32'(busy_o), 32'd0);
    @(posedge clk); #1;
    chk("t1_rst_memval", 32'(mem_val_o), 32'd0);
    chk("t1_rst_rdy", 32'(req_rdy_o), 32'd0);
    rst = 1'b0; mem_lat = 0; last = NREQ - 1;
    step();
    chk("t1_memval_c1", 32'(mem_val_o), 32'd1);
    chk("t1_addr_c1", 32'(mem_addr_o), 32'h10);
    chk("t1_gnt_c1", 32'(gnt_o), 32'b0010);
    serve(w, rd, g, n);
    chk("t1_winner", 32'(w), 32'd1);
    chk("t1_latency", 32'(n), 32'd1);
    chk("t1_rdata", 32'(rd), 32'(ref_mem[8'h10]));
    last = 1;
    idle();

    // Single read of the preloaded 0xBEEF word; rdy must last exactly one cycle.
    req_val[0] = 1'b1; req_wen[0] = 1'b0; req_addr[0] = 8'h42;
    txn("t2", 2, w, rd);
    chk("t2_rdata", 32'(rd), 32'hBEEF);
    chk("t2_rdy_vec", 32'(req_rdy_o), 32'b0001);
    req_val = '0;
    step();
    chk("t2_rdy_drop", 32'(req_rdy_o), 32'd0);
    step();

    req_val[1] = 1'b1; req_wen[1] = 1'b1; req_addr[1] = 8'hFF; req_wdata[1] = 16'h1234;
    txn("t3w", 2, w, rd);
    chk("t3w_log_wen", 32'(log_wen), 32'd1);
    chk("t3w_log_wdata", 32'(log_wdata), 32'h1234);
    req_wen[1] = 1'b0;
    txn("t3r", 3, w, rd);
    chk("t3r_rdata", 32'(rd), 32'h1234);
    chk("t3r_log_wen", 32'(log_wen), 32'd0);
    idle();

    // Two requesters held active for six transactions.
    req_val[0] = 1'b1; req_wen[0] = 1'b0; req_addr[0] = 8'h01;
    req_val[1] = 1'b1; req_wen[1] = 1'b0; req_addr[1] = 8'h02;
    for (int i = 0; i < 6; i++) begin
      txn("t4", (i == 0) ? 2 : 3, w, rd);
`ifdef MEM_ARB_FIXED_PRIO_EN
      chk("t4_order", 32'(w), 32'd0);
`else
      chk("t4_order", 32'(w), 32'(i % 2));
`endif
      if (w >= 0) req_addr[w] = 8'(8'h20 + i);
    end
    idle();

    // Memory stalls for ten cycles.
    mem_lat = 10;
    req_val[2] = 1'b1; req_wen[2] = 1'b0; req_addr[2] = 8'h77;
    step();
    chk("t5_memval_c1", 32'(mem_val_o), 32'd1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t5_stall_val", 32'(mem_val_o), 32'd1);
      chk("t5_stall_addr", 32'(mem_addr_o), 32'h77);
      chk("t5_stall_busy", 32'(busy_o), 32'd1);
      chk("t5_stall_rdy", 32'(req_rdy_o), 32'd0);
    end
    serve(w, rd, g, n);
    chk("t5_winner", 32'(w), 32'd2);
    chk("t5_latency_tail", 32'(n), 32'd1);
    chk("t5_rdata", 32'(rd), 32'(ref_mem[8'h77]));
    last = 2; mem_lat = 0;
    idle();

    // Fresh reset, then all four requesters active.
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0; last = NREQ - 1;
    for (int j = 0; j < NREQ; j++) begin
      req_val[j] = 1'b1; req_wen[j] = 1'b0; req_addr[j] = 8'(8'h30 + j);
    end
    for (int i = 0; i < 5; i++) begin
      txn("t6", (i == 0) ? 2 : 3, w, rd);
`ifdef MEM_ARB_FIXED_PRIO_EN
      chk("t6_seq", 32'(w), 32'd0);
`else
      chk("t6_seq", 32'(w), 32'(i % NREQ));
`endif
    end
    idle();

    // Random traffic: served requesters may chain a new op, idle ones may join.
    for (int it = 0; it < 40; it++) begin
      if (req_val == '0) new_op(int'($urandom_range(0, NREQ - 1)));
      txn("rnd", 0, w, rd);
      for (int j = 0; j < NREQ; j++) begin
        if (j == w) begin
          if ($urandom_range(0, 3) != 0) new_op(j);
          else req_val[j] = 1'b0;
        end else if (!req_val[j] && $urandom_range(0, 2) == 0) new_op(j);
      end
      mem_lat = $urandom_range(0, 3);
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
